// File: rtl/axi_read_lane_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_read_lane_bridge_if
// AXI read-channel bundle (AR + R) used on both sides of axi_read_lane_bridge.
// The upstream side uses a 32-bit instance and the downstream side a 64-bit one.
//
// Handshake rule for both channels: a beat transfers on a rising clock edge
// where valid and ready are both 1. Once valid is raised, it and its payload
// stay stable until that transfer. Ready may change freely.
//
// Signals:
//   arvalid/arready, araddr[ADDR_W], arid[ID_W], arsize[3], arlen[8], arburst[2]
//   rvalid/rready, rdata[DATA_W], rresp[2], rlast, rid[ID_W]
// Modports:
//   master : drives AR and rready; receives arready and the R payload
//   slave  : the reverse view
// ---------------------------------------------------------------------------
interface axi_read_lane_bridge_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic [2:0]        arsize;
   logic [7:0]        arlen;
   logic [1:0]        arburst;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID_W-1:0]   rid;

   modport master (
      output arvalid, araddr, arid, arsize, arlen, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  arvalid, araddr, arid, arsize, arlen, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/axi_read_lane_bridge.sv
// ---------------------------------------------------------------------------
// axi_read_lane_bridge
// Single-outstanding read bridge from the core's 32-bit AXI arbiter to the
// 64-bit io_master read port. A legal request (arsize <= 2, address aligned
// to its size) is forwarded as a single INCR beat. The 32-bit lane of the
// first returned beat is selected by address bit 2. Illegal requests are
// answered locally with ERR_RESP and never reach the downstream port.
//
// Ports:
//   clk        core clock
//   rst        synchronous reset, active-low
//   s          upstream slave side (32-bit data)
//   m          downstream master side (64-bit data)
//   state_dbg  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module axi_read_lane_bridge #(
   parameter int         ID_W     = 4,
   parameter int         ADDR_W   = 32,
   parameter logic [1:0] ERR_RESP = 2'b10
) (
   input  logic                          clk,
   input  logic                          rst,
   axi_read_lane_bridge_if.slave         s,
   axi_read_lane_bridge_if.master        m,
   output logic [1:0]                    state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   logic   got_beat;   // first R beat already captured; later beats only drain
   logic   req_legal;

   // Size must fit one 32-bit lane and the address must be naturally aligned.
   always_comb begin
      req_legal = 1'b0;
      case (s.arsize)
         3'd0:    req_legal = 1'b1;
         3'd1:    req_legal = ~s.araddr[0];
         3'd2:    req_legal = (s.araddr[1:0] == 2'b00);
         default: req_legal = 1'b0;
      endcase
   end

   assign m.arlen   = 8'd0;
   assign m.arburst = 2'b01;
   assign state_dbg = state;

   // Inputs intentionally ignored: the downstream ID and the upstream burst
   // fields (every request is treated as a single beat).
   logic unused_inputs;
   assign unused_inputs = ^{m.rid, s.arlen, s.arburst};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         got_beat  <= 1'b0;
         s.arready <= 1'b0;
         s.rvalid  <= 1'b0;
         s.rlast   <= 1'b0;
         s.rdata   <= '0;
         s.rresp   <= 2'b00;
         s.rid     <= '0;
         m.arvalid <= 1'b0;
         m.rready  <= 1'b0;
         m.araddr  <= '0;
         m.arid    <= '0;
         m.arsize  <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               s.arready <= 1'b1;
               if (s.arready && s.arvalid) begin
                  s.arready <= 1'b0;
                  m.araddr  <= s.araddr;
                  m.arid    <= s.arid;
                  m.arsize  <= s.arsize;
                  s.rid     <= s.arid;
                  got_beat  <= 1'b0;
                  if (req_legal) begin
                     m.arvalid <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     s.rdata  <= '0;
                     s.rresp  <= ERR_RESP;
                     s.rvalid <= 1'b1;
                     s.rlast  <= 1'b1;
                     state    <= RESP;
                  end
               end
            end

            ISSUE: begin
               if (m.arready) begin
                  m.arvalid <= 1'b0;
                  m.rready  <= 1'b1;
                  state     <= WAIT;
               end
            end

            // m.rready is 1 throughout WAIT, so m.rvalid alone marks a beat.
            WAIT: begin
               if (m.rvalid) begin
                  if (!got_beat) begin
                     s.rdata  <= m.araddr[2] ? m.rdata[63:32] : m.rdata[31:0];
                     s.rresp  <= m.rresp;
                     got_beat <= 1'b1;
                  end
                  if (m.rlast) begin
                     m.rready <= 1'b0;
                     s.rvalid <= 1'b1;
                     s.rlast  <= 1'b1;
                     state    <= RESP;
                  end
               end
            end

            RESP: begin
               if (s.rready) begin
                  s.rvalid  <= 1'b0;
                  s.rlast   <= 1'b0;
                  s.arready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_lane_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_read_lane_bridge
// Directed scenarios followed by randomized reads. Expected responses come
// from a small behavioural model (legality by modular arithmetic, lane by
// address/4 parity) and are queued in exp_q as {rid, rresp, rdata}.
// ---------------------------------------------------------------------------
module tb_axi_read_lane_bridge;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state_dbg;

   axi_read_lane_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(32)) s_if ();
   axi_read_lane_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(64)) m_if ();

   axi_read_lane_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W), .ERR_RESP(2'b10)) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (s_if),
      .m         (m_if),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- counters, scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_issues = 0;
   int exp_issues = 0;
   logic [37:0] exp_q[$];

   always @(posedge clk) begin
      if (rst && m_if.arvalid && m_if.arready) n_issues++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] size);
      longint unsigned bytes;
      bytes = longint'(1) << size;
      return (size <= 3'd2) && ((longint'(addr) % bytes) == 0);
   endfunction

   function automatic logic [37:0] model(input logic [31:0] addr, input logic [2:0] size,
                                         input logic [3:0] id, input logic [63:0] d0,
                                         input logic [1:0] r0);
      logic [31:0] data;
      logic [1:0]  resp;
      if (is_legal(addr, size)) begin
         data = (((addr / 4) % 2) == 1) ? 32'(d0 >> 32) : 32'(d0 % 64'h1_0000_0000);
         resp = r0;
      end else begin
         data = 32'd0;
         resp = 2'b10;
      end
      return {id, resp, data};
   endfunction

   // ---------------- driver ----------------
   // Entered and left at a negedge. Plays both the upstream master and the
   // downstream slave for one complete read.
   task automatic read_txn(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                           input logic [63:0] d0, input logic [1:0] r0, input int nbeats,
                           input int ar_wait, input int s_wait);
      logic        legal;
      logic [37:0] exp;
      int          cnt;
      legal = is_legal(addr, size);
      exp_q.push_back(model(addr, size, id, d0, r0));
      if (legal) exp_issues++;

      s_if.arvalid = 1'b1;
      s_if.araddr  = addr;
      s_if.arid    = id;
      s_if.arsize  = size;
      cnt = 0;
      while (s_if.arready !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 20) begin
         check("ar_accept_timeout", 1'b0, 1'b1);
         s_if.arvalid = 1'b0;
         void'(exp_q.pop_back());
         if (legal) exp_issues--;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      s_if.arvalid = 1'b0;
      s_if.araddr  = $urandom;
      s_if.arid    = 4'($urandom);
      s_if.arsize  = 3'($urandom);

      if (legal) begin
         check("m_arvalid_lat", m_if.arvalid, 1'b1);
         check("m_araddr", m_if.araddr, addr);
         check("m_arid", m_if.arid, id);
         check("m_arsize", m_if.arsize, size);
         check("m_arlen", m_if.arlen, 8'd0);
         check("m_arburst", m_if.arburst, 2'b01);
         for (int i = 0; i < ar_wait; i++) begin
            m_if.rvalid = 1'($urandom);
            m_if.rdata  = {$urandom, $urandom};
            m_if.rlast  = 1'($urandom);
            @(negedge clk);
            check("m_arvalid_hold", m_if.arvalid, 1'b1);
            check("m_araddr_stable", m_if.araddr, addr);
            check("m_arid_stable", m_if.arid, id);
            check("m_rready_issue", m_if.rready, 1'b0);
         end
         m_if.rvalid  = 1'b0;
         m_if.arready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         m_if.arready = 1'b0;
         check("m_arvalid_drop", m_if.arvalid, 1'b0);
         check("m_rready_wait", m_if.rready, 1'b1);
         for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               m_if.rvalid = 1'b0;
               @(negedge clk);
            end
            m_if.rvalid = 1'b1;
            m_if.rdata  = (b == 0) ? d0 : {$urandom, $urandom};
            m_if.rresp  = (b == 0) ? r0 : 2'($urandom);
            m_if.rlast  = (b == nbeats - 1);
            m_if.rid    = 4'($urandom);
            @(negedge clk);
         end
         m_if.rvalid = 1'b0;
         m_if.rlast  = 1'b0;
         check("s_rvalid_lat", s_if.rvalid, 1'b1);
      end else begin
         check("no_m_arvalid", m_if.arvalid, 1'b0);
         check("err_rvalid", s_if.rvalid, 1'b1);
      end

      exp = exp_q[0];
      for (int i = 0; i < s_wait; i++) begin
         check("s_rvalid_hold", s_if.rvalid, 1'b1);
         check("s_rdata_stable", s_if.rdata, exp[31:0]);
         check("m_rready_resp", m_if.rready, 1'b0);
         s_if.rready = 1'b0;
         m_if.rvalid = 1'($urandom);
         m_if.rdata  = {$urandom, $urandom};
         m_if.rresp  = 2'($urandom);
         m_if.rlast  = 1'($urandom);
         @(negedge clk);
      end
      m_if.rvalid = 1'b0;
      m_if.rlast  = 1'b0;
      s_if.rready = 1'b1;
      check("s_rvalid", s_if.rvalid, 1'b1);
      exp = exp_q.pop_front();
      check("s_rdata", s_if.rdata, exp[31:0]);
      check("s_rresp", s_if.rresp, exp[33:32]);
      check("s_rid", s_if.rid, exp[37:34]);
      check("s_rlast", s_if.rlast, 1'b1);
      if (!legal) check("no_m_arvalid_resp", m_if.arvalid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      s_if.rready = 1'b0;
      check("s_rvalid_clear", s_if.rvalid, 1'b0);
      check("s_arready_idle", s_if.arready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      s_if.arvalid = 1'b0; s_if.araddr = '0; s_if.arid = '0; s_if.arsize = '0;
      s_if.arlen = 8'd0; s_if.arburst = 2'b01; s_if.rready = 1'b0;
      m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0;
      m_if.rresp = 2'b00; m_if.rlast = 1'b0; m_if.rid = '0;

      repeat (3) @(negedge clk);
      check("rst_s_arready", s_if.arready, 1'b0);
      check("rst_s_rvalid", s_if.rvalid, 1'b0);
      check("rst_m_arvalid", m_if.arvalid, 1'b0);
      check("rst_m_rready", m_if.rready, 1'b0);
      check("rst_s_rdata", s_if.rdata, 32'd0);
      check("rst_s_rresp", s_if.rresp, 2'b00);
      check("rst_s_rid", s_if.rid, 4'd0);
      rst = 1'b1;
      @(negedge clk);
      check("arready_after_rst", s_if.arready, 1'b1);

      // lane select
      read_txn(32'h8000_0004, 4'd5, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1, 0, 0);
      // misaligned and oversize
      read_txn(32'h8000_0002, 4'd6, 3'd2, 64'h0, 2'b00, 1, 0, 0);
      read_txn(32'h8000_0002, 4'd7, 3'd3, 64'h0, 2'b00, 1, 0, 0);
      // backpressure on both sides
      read_txn(32'h8000_0010, 4'd9, 3'd2, 64'h1234_5678_9ABC_DEF0, 2'b00, 1, 5, 3);
      // error pass-through with drain beat
      read_txn(32'h8000_0020, 4'd3, 3'd2, 64'h0BAD_0BAD_5555_6666, 2'b11, 2, 0, 0);

      // reset in WAIT
      s_if.arvalid = 1'b1; s_if.araddr = 32'h0000_0010; s_if.arid = 4'd7; s_if.arsize = 3'd2;
      for (int i = 0; i < 20 && s_if.arready !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      s_if.arvalid = 1'b0;
      exp_issues++;
      m_if.arready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_if.arready = 1'b0;
      check("wait_before_rst", m_if.rready, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = {$urandom, $urandom};
      check("midrst_s_rvalid", s_if.rvalid, 1'b0);
      check("midrst_m_arvalid", m_if.arvalid, 1'b0);
      check("midrst_m_rready", m_if.rready, 1'b0);
      check("midrst_s_rdata", s_if.rdata, 32'd0);
      check("midrst_s_rid", s_if.rid, 4'd0);
      @(negedge clk);
      m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
      check("midrst_idle_m_rready", m_if.rready, 1'b0);
      check("midrst_idle_s_rvalid", s_if.rvalid, 1'b0);
      read_txn(32'h0000_0014, 4'd8, 3'd2, 64'hFEED_FACE_CAFE_BEEF, 2'b01, 1, 0, 0);

      // back-to-back, zero-wait
      for (int i = 0; i < 4; i++)
         read_txn(32'(i * 4), 4'(i), 3'd2, 64'h1111_2222_3333_4444 + 64'(i), 2'b00, 1, 0, 0);

      // randomized
      for (int i = 0; i < 40; i++)
         read_txn({$urandom_range(0, 32'hFFFF), 16'($urandom)}, 4'($urandom), 3'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 2'($urandom), $urandom_range(1, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));

      check("ar_handshake_count", 64'(n_issues), 64'(exp_issues));
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
